// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Instruction-fetch controller. Owns the program counter, issues one request
// at a time to instruction memory, and hands each fetched word and its PC to
// decode through a single-entry output buffer with a valid/ready handshake.
// Control-flow redirects from execute replace the PC and flush the buffer.
// Stalls from the hazard unit block new requests and consumption.
// Memory latency may be zero (ack combinational from req) or any number of
// cycles.
//
// Ports
//   clk                clock, all state updates on posedge
//   rst                synchronous active-high reset, highest priority
//   stall_i            hazard stall: no new request, no consumption
//   redirect_i         single-cycle control-flow change pulse
//   redirect_target_i  new PC; bits [1:0] are ignored
//   imem_req_o         request outstanding (registered)
//   imem_addr_o        address of the outstanding request (registered)
//   imem_ack_i         memory returns data this cycle
//   imem_rdata_i       instruction word, valid with imem_ack_i
//   if_valid_o         output buffer holds an instruction
//   if_pc_o            PC of the buffered instruction
//   if_instr_o         buffered instruction
//   if_ready_i         decode accepts the buffered instruction
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_target_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ack_i,
    input  logic [31:0]           imem_rdata_i,
    output logic                  if_valid_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [31:0]           if_instr_o,
    input  logic                  if_ready_i
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;

    logic                  consume;
    logic                  space;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] pc_seq;

    // No compressed instructions, so redirect targets are forced word-aligned.
    function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(3);
    endfunction

    // Sequential successor; the addition wraps modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] next_word(input logic [ADDR_WIDTH-1:0] a);
        return a + ADDR_WIDTH'(4);
    endfunction

    assign consume = if_valid_o & if_ready_i & ~stall_i;
    assign space   = ~if_valid_o | consume;
    // A request is only issued when the buffer will have room, so an ack in
    // WAIT can never overwrite an instruction decode has not yet taken.
    assign issue   = ~stall_i & ~redirect_i & space;
    assign target  = align_word(redirect_target_i);
    assign pc_seq  = next_word(pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            imem_req_o  <= 1'b0;
            imem_addr_o <= '0;
            if_valid_o  <= 1'b0;
            if_pc_o     <= '0;
            if_instr_o  <= '0;
        end else begin
            // Decode taking the buffered instruction empties the buffer unless
            // a capture below refills it on the same edge.
            if (consume) begin
                if_valid_o <= 1'b0;
            end

            // A redirect flushes the buffer even if decode accepts it now.
            if (redirect_i) begin
                if_valid_o <= 1'b0;
            end

            case (state)
                BOOT: begin
                    if (redirect_i) begin
                        pc <= target;
                    end
                    state <= IDLE;
                end

                IDLE: begin
                    if (redirect_i) begin
                        pc <= target;
                    end else if (issue) begin
                        imem_addr_o <= pc;
                        imem_req_o  <= 1'b1;
                        state       <= WAIT;
                    end
                end

                WAIT: begin
                    if (imem_ack_i) begin
                        imem_req_o <= 1'b0;
                        state      <= IDLE;
                        if (redirect_i) begin
                            pc <= target;
                        end else begin
                            if_instr_o <= imem_rdata_i;
                            if_pc_o    <= imem_addr_o;
                            if_valid_o <= 1'b1;
                            pc         <= pc_seq;
                        end
                    end else if (redirect_i) begin
                        // The old request cannot be withdrawn; keep it asserted
                        // with its address and throw its data away in DROP.
                        pc    <= target;
                        state <= DROP;
                    end
                end

                DROP: begin
                    if (redirect_i) begin
                        pc <= target;
                    end
                    if (imem_ack_i) begin
                        imem_req_o <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    imem_req_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Directed bench for pc_fetch_sequencer. The memory model returns a word
// derived from the address, with a programmable ack delay counted from the
// first cycle the request is seen (delay 0 gives a combinational ack).
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    int total;
    int bad;
    int ack_delay;
    int req_cnt;

    pc_fetch_sequencer #(
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall),
        .redirect_i        (redirect),
        .redirect_target_i (target),
        .imem_req_o        (imem_req),
        .imem_addr_o       (imem_addr),
        .imem_ack_i        (imem_ack),
        .imem_rdata_i      (imem_rdata),
        .if_valid_o        (if_valid),
        .if_pc_o           (if_pc),
        .if_instr_o        (if_instr),
        .if_ready_i        (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = imem_req && (req_cnt >= ack_delay);

    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ack) begin
            req_cnt <= 0;
        end else begin
            req_cnt <= req_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, "_addr"}, imem_addr, addr);
    endtask

    task automatic exp_buf(input string tag, input logic vld, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, vld});
        if (vld) begin
            chk({tag, "_pc"}, if_pc, pc);
            chk({tag, "_instr"}, if_instr, mem_word(pc));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        target = '0;
        if_ready = 1'b1;
        ack_delay = 0;

        tick;
        tick;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        rst = 1'b0;

        // BOOT -> IDLE, then IDLE issues, then WAIT captures
        tick;
        exp_req("boot", 1'b0, 32'd0);
        tick;
        exp_req("f0", 1'b1, 32'h0);
        exp_buf("f0", 1'b0, 32'h0);
        tick;
        exp_buf("i0", 1'b1, 32'h0);
        exp_req("i0", 1'b0, 32'h0);
        tick;
        exp_req("f1", 1'b1, 32'h4);
        exp_buf("f1", 1'b0, 32'h0);
        tick;
        exp_buf("i1", 1'b1, 32'h4);
        tick;
        exp_req("f2", 1'b1, 32'h8);
        if_ready = 1'b0;
        tick;
        exp_buf("i2", 1'b1, 32'h8);

        // decode back-pressure: buffer holds, no request
        for (int i = 0; i < 5; i++) begin
            tick;
            exp_buf("hold", 1'b1, 32'h8);
            exp_req("hold", 1'b0, 32'h0);
        end
        if_ready = 1'b1;
        tick;
        exp_req("f3", 1'b1, 32'hC);
        exp_buf("f3", 1'b0, 32'h0);
        tick;
        exp_buf("i3", 1'b1, 32'hC);

        // slow ack, redirect on the 2nd WAIT cycle -> DROP
        ack_delay = 3;
        tick;
        exp_req("dw1", 1'b1, 32'h10);
        tick;
        exp_req("dw2", 1'b1, 32'h10);
        redirect = 1'b1;
        target = 32'h107;
        tick;
        redirect = 1'b0;
        exp_req("drop1", 1'b1, 32'h10);
        exp_buf("drop1", 1'b0, 32'h0);
        tick;
        exp_req("drop2", 1'b1, 32'h10);
        chk("drop2_ack", {31'd0, imem_ack}, 32'd1);
        tick;
        exp_req("dropped", 1'b0, 32'h0);
        exp_buf("dropped", 1'b0, 32'h0);
        ack_delay = 0;
        tick;
        exp_req("rd", 1'b1, 32'h104);
        tick;
        exp_buf("rd", 1'b1, 32'h104);

        // redirect coincident with ack in WAIT
        tick;
        exp_req("f5", 1'b1, 32'h108);
        redirect = 1'b1;
        target = 32'h200;
        tick;
        redirect = 1'b0;
        exp_buf("coinc", 1'b0, 32'h0);
        exp_req("coinc", 1'b0, 32'h0);
        tick;
        exp_req("f6", 1'b1, 32'h200);
        tick;
        exp_buf("i6", 1'b1, 32'h200);

        // stall in IDLE
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            exp_req("stall", 1'b0, 32'h0);
            exp_buf("stall", 1'b1, 32'h200);
        end
        stall = 1'b0;
        tick;
        exp_req("f7", 1'b1, 32'h204);
        // stall during WAIT does not cancel the request
        stall = 1'b1;
        tick;
        exp_buf("i7", 1'b1, 32'h204);
        exp_req("i7", 1'b0, 32'h0);
        tick;
        exp_req("stall2", 1'b0, 32'h0);
        exp_buf("stall2", 1'b1, 32'h204);
        stall = 1'b0;
        tick;
        exp_req("f8", 1'b1, 32'h208);

        // PC wrap at the top of the address space
        redirect = 1'b1;
        target = 32'hFFFF_FFFF;
        tick;
        redirect = 1'b0;
        exp_buf("rw", 1'b0, 32'h0);
        tick;
        exp_req("f9", 1'b1, 32'hFFFF_FFFC);
        tick;
        exp_buf("i9", 1'b1, 32'hFFFF_FFFC);
        ack_delay = 5;
        tick;
        exp_req("wrap", 1'b1, 32'h0);
        tick;
        exp_req("wrap_wait", 1'b1, 32'h0);

        // reset in the middle of an outstanding request
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ack_delay = 0;
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_valid", {31'd0, if_valid}, 32'd0);
        chk("mrst_pc", if_pc, 32'd0);
        chk("mrst_addr", imem_addr, 32'd0);
        tick;
        exp_req("mboot", 1'b0, 32'h0);
        tick;
        exp_req("rs", 1'b1, 32'h0);
        tick;
        exp_buf("rs", 1'b1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Instruction-fetch controller for the RISC-V core: owns the program counter and sequences requests to instruction memory.
- Applies control-flow redirects (taken branch, jal, jalr) from execute and honours stalls from the hazard unit.
- Presents one fetched instruction and its PC to decode over a valid/ready handshake.
- Replaces the free-running PC register with a handshake-aware sequencer that supports variable-latency memory.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset
- stall_i  in  1  hazard stall; blocks new requests and consumption
- redirect_i  in  1  control-flow change, single-cycle pulse
- redirect_target_i  in  ADDR_WIDTH  new PC (branch PC+imm, or jalr rs1+imm)
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_WIDTH  fetch address; stable while imem_req_o=1
- imem_ack_i  in  1  memory returns data this cycle; may be combinational from req
- imem_rdata_i  in  32  instruction word, valid when imem_ack_i=1
- if_valid_o  out  1  output buffer holds an instruction
- if_pc_o  out  ADDR_WIDTH  PC of buffered instruction
- if_instr_o  out  32  buffered instruction
- if_ready_i  in  1  decode accepts the buffered instruction

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. rst=1 at a posedge sets state=BOOT, pc=RESET_PC, if_valid_o=0, if_pc_o=0, if_instr_o=0, imem_req_o=0, imem_addr_o=0. rst has priority over every other input. A reset during an outstanding request abandons it; imem is reset by the same rst.
- Derived signals:
  - consume = if_valid_o & if_ready_i & ~stall_i
  - space = ~if_valid_o | consume
  - issue = ~stall_i & ~redirect_i & space
- Outputs by state: imem_req_o=1 only in WAIT and DROP. imem_addr_o = registered address of the outstanding request; it holds its value otherwise.
- consume clears if_valid_o at the edge, unless the same edge loads a new instruction.
- Target alignment: redirect_target_i[1:0] are ignored and treated as 2'b00 (no compressed ISA).
- PC arithmetic: pc+4 is modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC wraps to 0.
- States:
  - BOOT: next state is IDLE. A redirect in BOOT loads pc=target.
  - IDLE:
    - redirect_i: pc<=target, if_valid_o<=0, stay IDLE.
    - else issue: latch imem_addr_o<=pc, go to WAIT.
    - else stay IDLE.
  - WAIT (request outstanding):
    - ack & ~redirect: if_instr_o<=rdata, if_pc_o<=imem_addr_o, if_valid_o<=1, pc<=pc+4, go to IDLE.
    - ack & redirect: discard data, pc<=target, if_valid_o<=0, go to IDLE.
    - ~ack & redirect: pc<=target, if_valid_o<=0, go to DROP; request stays asserted with the old address.
    - ~ack & ~redirect: stay WAIT. stall_i does not cancel an outstanding request.
  - DROP:
    - Hold req until ack; on ack, discard data and go to IDLE.
    - A further redirect in DROP overwrites pc and stays DROP, or goes to IDLE if ack arrives the same cycle.
- Output buffer: guaranteed empty in WAIT, because issue required space. An ack in WAIT therefore never overwrites a valid instruction.
- Latency and throughput: with an ack combinational to req, a new instruction is at most one every 2 cycles. From reset release to the first if_valid_o: BOOT 1 cycle, IDLE 1 cycle, WAIT 1 cycle, so if_valid_o=1 in the 4th cycle.
- Redirect priority: redirect > stall > issue. The flush kills a buffered instruction even if decode accepts it in the same cycle; the redirect source must account for this.

Test Plan:
- Reset, RESET_PC=0, ack tied to req, if_ready_i=1: if_pc_o sequence 0x0, 0x4, 0x8, one new instruction every 2 cycles; if_instr_o matches memory words.
- if_ready_i=0 for 5 cycles while if_valid_o=1 at PC 0x8: if_pc_o and if_instr_o stable, imem_req_o=0; after ready rises, next fetch address is 0xC.
- Ack delayed 3 cycles, redirect to 0x104 on the 2nd WAIT cycle: state goes to DROP, req stays asserted with the old address; the late data is discarded; next request address is 0x104 (low bits cleared); no instruction from the old stream appears.
- Redirect to 0x200 coincident with ack in WAIT: data dropped, next request address 0x200, if_valid_o=0 that cycle.
- stall_i=1 in IDLE for 4 cycles: no request issued, pc held; stall asserted during WAIT: ack still captured, pc advances by 4.
- pc=0xFFFF_FFFC fetched: next address 0x0. rst pulsed mid-WAIT: next cycle imem_req_o=0, if_valid_o=0, fetch restarts at RESET_PC.
